iter_mul_unit: RTL
==================

// Module: iter_mul_unit
// PURPOSE
// - Iterative shift-add multiplier in the execute stage, beside the ALU. Computes a 2*WIDTH-bit signed or
//   unsigned product of two WIDTH-bit operands taken from the ID/EX pipeline register.
// - Drives stall_req into the hazard logic. That logic deasserts the enables of the F/D/E flopenr
//   registers while the multiply runs.
// - Returns the product one cycle after the last iteration, for the EX/MEM register.
// PARAMETERS
// - WIDTH  32  operand width in bits; product is 2*WIDTH bits; must be >= 2
// PORTS
// - clk        in   1        clock, rising edge
// - reset      in   1        asynchronous, active-high reset
// - start      in   1        request a multiply, sampled in IDLE or DONE
// - signed_op  in   1        1 = two's-complement operands (SMULL), 0 = unsigned (UMULL)
// - a          in   WIDTH    multiplicand, sampled with start
// - b          in   WIDTH    multiplier, sampled with start
// - flush      in   1        cancel in-flight op (branch taken / FlushE)
// - stall_req  out  1        combinational: hold upstream pipeline registers
// - busy       out  1        registered: state == RUN
// - done       out  1        one-cycle pulse: product valid
// - result_hi  out  WIDTH    upper half of product
// - result_lo  out  WIDTH    lower half of product
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, count=0, busy=0, done=0, result_hi=result_lo=0, internal regs=0.
// - FSM states: IDLE, RUN, DONE.
//   - IDLE: start & ~flush -> RUN. Otherwise stay in IDLE.
//   - RUN: flush -> IDLE. count==0 -> DONE. Otherwise stay in RUN, count--.
//   - DONE: start & ~flush -> RUN (back-to-back). Otherwise -> IDLE.
// - Accept, on the edge leaving IDLE/DONE with start:
//   - Latch |a| and |b|: magnitude when signed_op and MSB=1, else the raw value.
//   - Latch neg = signed_op & (a[MSB]^b[MSB]).
//   - Clear the 2*WIDTH accumulator. Load count=WIDTH-1.
// - Magnitude width rules:
//   - |x| is computed as an unsigned WIDTH-bit value.
//   - The most-negative operand (0x80..0) therefore maps to 2^(WIDTH-1) correctly.
// - Each RUN cycle does one iteration:
//   - If the multiplier LSB is 1, accumulator += multiplicand shifted.
//   - Multiplicand shifts left by 1, multiplier shifts right by 1.
//   - Adds are 2*WIDTH bits wide with no overflow.
// - Entering DONE:
//   - {result_hi,result_lo} = neg ? -acc : acc, computed mod 2^(2*WIDTH).
//   - done=1 for exactly the DONE cycle.
// - Result holding:
//   - result_hi/lo hold their value until the next DONE entry.
//   - A flush or an ignored start does not change them.
// - Latency: start accepted at cycle T -> RUN in cycles T+1..T+WIDTH -> done=1 in cycle T+WIDTH+1.
// - stall_req = (start & ~flush & (IDLE|DONE)) | RUN. It is high in cycles T..T+WIDTH and low while done=1,
//   unless a new start is accepted.
// - Boundary cases:
//   - start during RUN is ignored. The operands are not resampled.
//   - flush has priority over start in every state.
//   - flush in DONE still lets done=1 show for that cycle, because done is already registered.
//     The consumer gates it with FlushE.
//   - Operand changes on a/b during RUN have no effect.
//   - reset mid-RUN aborts immediately. No done is produced.
// TESTING
// - Unsigned 3*5, start at cycle 0 -> stall_req high for cycles 0..32; done=1 only at cycle 33;
//   hi=0x00000000, lo=0x0000000F.
// - Signed -7*3 (a=0xFFFFFFF9, b=3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
// - Unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
// - Signed 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
// - Signed 0x80000000*1 -> hi=0xFFFFFFFF, lo=0x80000000.
// - Flush at cycle 10 of a run -> IDLE at cycle 11; no done; result equals the previous product.
//   Start plus flush in the same IDLE cycle -> no accept.
// - Start held in DONE with 2*2 after 3*5 -> done at 33 with 15, then done at 66 with 4.
//   Async reset at cycle 20 -> all outputs 0 immediately, and no done follows.

Source files
------------

// File: rtl/iter_mul_unit.sv
// iter_mul_unit: iterative shift-add signed/unsigned multiplier with pipeline stall request
module iter_mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall_req,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] mcand, acc, acc_nxt, prod;
    logic [WIDTH-1:0]   mplier, abs_a, abs_b;
    logic               neg, accept;
    assign accept    = start & ~flush & (state == IDLE || state == DONE);
    assign stall_req = accept | (state == RUN);
    assign abs_a     = (signed_op & a[WIDTH-1]) ? -a : a;
    assign abs_b     = (signed_op & b[WIDTH-1]) ? -b : b;
    assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
    // the final iteration's add feeds the result directly so done lands one cycle after it
    assign prod      = neg ? -acc_nxt : acc_nxt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            neg       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    busy  <= accept;
                    state <= accept ? RUN : IDLE;
                    if (accept) begin
                        mcand  <= {{WIDTH{1'b0}}, abs_a};
                        mplier <= abs_b;
                        acc    <= '0;
                        neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        count  <= CW'(WIDTH - 1);
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        if (count == '0) begin
                            state                  <= DONE;
                            busy                   <= 1'b0;
                            done                   <= 1'b1;
                            {result_hi, result_lo} <= prod;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
